cpu_core_mc: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle 20-bit teaching CPU.
- Fetches instructions over a variable-latency req/valid port and executes from a register file plus internal data RAM.
- Sequenced by an explicit FSM with reset, halt and retire reporting.
- Sits between the instruction ROM wrapper and the top-level testbench/top.

---
 rtl/cpu_pkg.sv | 56 +++++
 rtl/cpu_regfile.sv | 35 +++
 rtl/cpu_core_mc.sv | 157 +++++++++++++++
 tb/tb_cpu_core_mc.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle 20-bit core: opcodes, instruction fields, FSM states.
package cpu_pkg;

    localparam int unsigned INSTR_W = 20;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_BEQ  = 4'hA;
    localparam logic [3:0] OP_BNE  = 4'hB;
    localparam logic [3:0] OP_JR   = 4'hC;
    localparam logic [3:0] OP_NOPD = 4'hD;
    localparam logic [3:0] OP_NOPE = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int unsigned OP_MSB    = 19;
    localparam int unsigned OP_LSB    = 16;
    localparam int unsigned RD_LSB    = 12;
    localparam int unsigned RS1_LSB   = 8;
    localparam int unsigned RS2_LSB   = 4;
    localparam int unsigned IMM8_MSB  = 7;
    localparam int unsigned IMM12_MSB = 11;

    typedef enum logic [1:0] {
        StFetch,
        StExec,
        StMem,
        StHalt
    } state_e;

    // Wide enough for any sane DATA_W; callers truncate with a size cast.
    localparam int unsigned SEXT_W = 64;

    function automatic logic [SEXT_W-1:0] sext8(input logic [7:0] imm8,
                                                input int unsigned data_w);
        logic [SEXT_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            r[i] = imm8[i];
        end
        for (int unsigned i = 8; i < SEXT_W; i++) begin
            if (i < data_w) begin
                r[i] = imm8[7];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// NREG x DATA_W register file: two async read ports, one sync write port, R0 hard zero.
module cpu_regfile #(
    parameter int unsigned DATA_W = 20,
    parameter int unsigned NREG   = 16,
    localparam int unsigned RW    = $clog2(NREG)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [RW-1:0]     ra_addr_i,
    output logic [DATA_W-1:0] ra_data_o,
    input  logic [RW-1:0]     rb_addr_i,
    output logic [DATA_W-1:0] rb_data_o,
    input  logic              we_i,
    input  logic [RW-1:0]     wa_i,
    input  logic [DATA_W-1:0] wd_i
);

    logic [DATA_W-1:0] regs_q [NREG];

    // Clear on reset; writes to R0 are dropped so it stays zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            regs_q <= '{default: '0};
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    // Asynchronous reads with R0 forced to zero.
    always_comb begin
        ra_data_o = (ra_addr_i == '0) ? '0 : regs_q[ra_addr_i];
        rb_data_o = (rb_addr_i == '0) ? '0 : regs_q[rb_addr_i];
    end

endmodule

// File: rtl/cpu_core_mc.sv
// Multi-cycle core: FETCH -> EXEC (-> MEM for loads) with a req/valid instruction port.
module cpu_core_mc
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W     = 20,
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned NREG       = 16,
    parameter int unsigned DMEM_DEPTH = 64,
    parameter int unsigned RESET_PC   = 0,
    parameter int unsigned CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               halted,
    output logic               retire,
    output logic [CNT_W-1:0]   retire_cnt
);

    localparam int unsigned RW = $clog2(NREG);
    localparam int unsigned DW = $clog2(DMEM_DEPTH);

    state_e             state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [INSTR_W-1:0] ir_q;
    logic               retire_q;
    logic               halted_q;
    logic [CNT_W-1:0]   cnt_q;

    // Zeroed at simulation start only; reset deliberately leaves contents intact.
    logic [DATA_W-1:0]  dmem [DMEM_DEPTH] = '{default: '0};
    logic [DATA_W-1:0]  mem_rdata_q;

    logic [3:0]         op;
    logic [RW-1:0]      rd_idx, rs1_idx, rs2_idx, rb_idx;
    logic [7:0]         imm8;
    logic [11:0]        imm12;
    logic [DATA_W-1:0]  a_val, b_val, alu_res, rf_wd;
    logic [ADDR_W-1:0]  pc_inc, pc_exec;
    logic               rf_we;

    assign op      = ir_q[OP_MSB:OP_LSB];
    assign rd_idx  = ir_q[RD_LSB +: RW];
    assign rs1_idx = ir_q[RS1_LSB +: RW];
    assign rs2_idx = ir_q[RS2_LSB +: RW];
    assign imm8    = ir_q[IMM8_MSB:0];
    assign imm12   = ir_q[IMM12_MSB:0];

    // ST and the branches read rd as their second operand instead of rs2.
    assign rb_idx = (op == OP_ST || op == OP_BEQ || op == OP_BNE) ? rd_idx : rs2_idx;

    assign rf_we = ((state_q == StExec) && (op <= OP_LDI)) || (state_q == StMem);
    assign rf_wd = (state_q == StMem) ? mem_rdata_q : alu_res;

    cpu_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk_i     (clk),
        .rst_i     (rst),
        .ra_addr_i (rs1_idx),
        .ra_data_o (a_val),
        .rb_addr_i (rb_idx),
        .rb_data_o (b_val),
        .we_i      (rf_we),
        .wa_i      (rd_idx),
        .wd_i      (rf_wd)
    );

    // ALU result and next PC for the instruction held in ir_q.
    always_comb begin
        alu_res = '0;
        pc_inc  = pc_q + ADDR_W'(1);
        pc_exec = pc_inc;
        case (op)
            OP_ADD:  alu_res = a_val + b_val;
            OP_SUB:  alu_res = a_val - b_val;
            OP_AND:  alu_res = a_val & b_val;
            OP_OR:   alu_res = a_val | b_val;
            OP_XOR:  alu_res = a_val ^ b_val;
            OP_ADDI: alu_res = a_val + DATA_W'(sext8(imm8, DATA_W));
            OP_LDI:  alu_res = DATA_W'(imm8);
            OP_JMP:  pc_exec = ADDR_W'(imm12);
            OP_BEQ:  if (b_val == a_val) pc_exec = ADDR_W'(imm8);
            OP_BNE:  if (b_val != a_val) pc_exec = ADDR_W'(imm8);
            OP_JR:   pc_exec = ADDR_W'(a_val);
            default: ;
        endcase
    end

    // Data RAM: synchronous write for ST, registered read for LD.
    always_ff @(posedge clk) begin
        if (state_q == StExec && op == OP_ST) begin
            dmem[a_val[DW-1:0]] <= b_val;
        end
        if (state_q == StExec && op == OP_LD) begin
            mem_rdata_q <= dmem[a_val[DW-1:0]];
        end
    end

    // Main sequencer with registered retire/halted outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StFetch;
            pc_q     <= ADDR_W'(RESET_PC);
            ir_q     <= '0;
            retire_q <= 1'b0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            retire_q <= 1'b0;
            case (state_q)
                StFetch: begin
                    if (imem_valid) begin
                        ir_q    <= imem_rdata;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (op == OP_LD) begin
                        state_q <= StMem;
                    end else if (op == OP_HALT) begin
                        retire_q <= 1'b1;
                        cnt_q    <= cnt_q + CNT_W'(1);
                        halted_q <= 1'b1;
                        state_q  <= StHalt;
                    end else begin
                        retire_q <= 1'b1;
                        cnt_q    <= cnt_q + CNT_W'(1);
                        pc_q     <= pc_exec;
                        state_q  <= StFetch;
                    end
                end
                StMem: begin
                    retire_q <= 1'b1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    pc_q     <= pc_inc;
                    state_q  <= StFetch;
                end
                default: ;
            endcase
        end
    end

    // Request is masked while reset is held even though the state is already FETCH.
    assign imem_req   = (state_q == StFetch) && !rst;
    assign imem_addr  = pc_q;
    assign pc_out     = pc_q;
    assign halted     = halted_q;
    assign retire     = retire_q;
    assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_core_mc.sv
// Directed bench for cpu_core_mc with a wait-state capable instruction memory model.
module tb_cpu_core_mc;

    localparam logic [19:0] I_HALT = 20'hF0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [19:0] imem_rdata = 20'h0;
    logic [11:0] pc_out;
    logic        halted;
    logic        retire;
    logic [31:0] retire_cnt;

    logic [19:0] prog [4096];
    int          wait_n = 0;
    int          wait_cnt = 0;
    bit          spurious = 1'b0;
    int          cyc;
    int          retire_times [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    cpu_core_mc dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .pc_out     (pc_out),
        .halted     (halted),
        .retire     (retire),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    // Instruction memory: wait_n invalid cycles per fetch, optional junk valid while idle.
    always @(negedge clk) begin
        if (imem_req) begin
            if (wait_cnt < wait_n) begin
                imem_valid = 1'b0;
                wait_cnt   = wait_cnt + 1;
            end else begin
                imem_valid = 1'b1;
                imem_rdata = prog[imem_addr];
            end
        end else begin
            wait_cnt   = 0;
            imem_valid = spurious;
            imem_rdata = I_HALT;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!rst && retire === 1'b1) retire_times.push_back(cyc);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 4096; i++) prog[i] = I_HALT;
    endtask

    task automatic release_rst();
        @(posedge clk);
        #2;
        rst = 1'b0;
        retire_times.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        release_rst();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %0h want 0", imem_req); end
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL rst_halted: got %0h want 0", halted); end
        n_cmp++; if (retire !== 1'b0) begin n_bad++; $display("FAIL rst_retire: got %0h want 0", retire); end
        n_cmp++; if (retire_cnt !== 32'd0) begin n_bad++; $display("FAIL rst_cnt: got %0h want 0", retire_cnt); end
        n_cmp++; if (pc_out !== 12'h000) begin n_bad++; $display("FAIL rst_pc: got %0h want 0", pc_out); end
    endtask

    task automatic test_arith();
        clear_prog();
        prog[0] = 20'h61005;  // LDI R1,5
        prog[1] = 20'h62003;  // LDI R2,3
        prog[2] = 20'h13120;  // SUB R3,R1,R2
        prog[3] = 20'h543FF;  // ADDI R4,R3,-1
        do_reset();
        step(8);
        n_cmp++; if (retire_cnt !== 32'd4) begin n_bad++; $display("FAIL arith_cnt: got %0d want 4", retire_cnt); end
        n_cmp++; if (dut.u_regfile.regs_q[1] !== 20'd5) begin n_bad++; $display("FAIL arith_r1: got %0h want 5", dut.u_regfile.regs_q[1]); end
        n_cmp++; if (dut.u_regfile.regs_q[3] !== 20'd2) begin n_bad++; $display("FAIL arith_r3: got %0h want 2", dut.u_regfile.regs_q[3]); end
        n_cmp++; if (dut.u_regfile.regs_q[4] !== 20'd1) begin n_bad++; $display("FAIL arith_r4: got %0h want 1", dut.u_regfile.regs_q[4]); end
        n_cmp++; if (imem_addr !== 12'h004) begin n_bad++; $display("FAIL arith_pc: got %0h want 4", imem_addr); end
    endtask

    task automatic test_memory();
        clear_prog();
        prog[0] = 20'h61007;  // LDI R1,7
        prog[1] = 20'h62009;  // LDI R2,9
        prog[2] = 20'h82100;  // ST R2,[R1]
        prog[3] = 20'h75100;  // LD R5,[R1]
        do_reset();
        step(12);
        n_cmp++; if (dut.u_regfile.regs_q[5] !== 20'd9) begin n_bad++; $display("FAIL mem_r5: got %0h want 9", dut.u_regfile.regs_q[5]); end
        n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL mem_halted: got %0h want 1", halted); end
        n_cmp++;
        if (retire_times.size() != 5) begin
            n_bad++; $display("FAIL mem_retires: got %0d want 5", retire_times.size());
        end else begin
            n_cmp++; if (retire_times[1] - retire_times[0] != 2) begin n_bad++; $display("FAIL mem_alu_gap: got %0d want 2", retire_times[1] - retire_times[0]); end
            n_cmp++; if (retire_times[3] - retire_times[2] != 3) begin n_bad++; $display("FAIL mem_ld_gap: got %0d want 3", retire_times[3] - retire_times[2]); end
        end
    endtask

    task automatic test_branch();
        clear_prog();
        prog[0]     = 20'h61004;  // LDI R1,4
        prog[1]     = 20'hA1110;  // BEQ R1,R1,0x10
        prog[12'h10] = 20'hB1120; // BNE R1,R1,0x20
        prog[12'h11] = 20'hC0100; // JR R1
        do_reset();
        step(4);
        n_cmp++; if (imem_addr !== 12'h010) begin n_bad++; $display("FAIL beq_taken: got %0h want 10", imem_addr); end
        step(2);
        n_cmp++; if (imem_addr !== 12'h011) begin n_bad++; $display("FAIL bne_fall: got %0h want 11", imem_addr); end
        step(2);
        n_cmp++; if (imem_addr !== 12'h004) begin n_bad++; $display("FAIL jr: got %0h want 4", imem_addr); end
    endtask

    task automatic test_wait_states();
        clear_prog();
        prog[0] = 20'h6602A;  // LDI R6,0x2A
        prog[1] = 20'h07660;  // ADD R7,R6,R6
        wait_n   = 5;
        spurious = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1);
            n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 12'h000) begin n_bad++; $display("FAIL wait_hold%0d: got req=%0h addr=%0h want req=1 addr=0", i, imem_req, imem_addr); end
        end
        step(16);
        n_cmp++; if (retire_cnt !== 32'd3) begin n_bad++; $display("FAIL wait_cnt: got %0d want 3", retire_cnt); end
        n_cmp++; if (dut.u_regfile.regs_q[7] !== 20'h54) begin n_bad++; $display("FAIL wait_r7: got %0h want 54", dut.u_regfile.regs_q[7]); end
        n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL wait_halted: got %0h want 1", halted); end
        step(1);
        n_cmp++; if (retire_times.size() != 3) begin n_bad++; $display("FAIL wait_pulses: got %0d want 3", retire_times.size()); end
        wait_n   = 0;
        spurious = 1'b0;
    endtask

    task automatic test_wrap_r0();
        clear_prog();
        prog[0]      = 20'h90FFF; // JMP 0xFFF
        prog[12'hFFF] = 20'hD0000; // NOP
        do_reset();
        step(2);
        n_cmp++; if (imem_addr !== 12'hFFF) begin n_bad++; $display("FAIL jmp: got %0h want fff", imem_addr); end
        step(2);
        n_cmp++; if (imem_addr !== 12'h000) begin n_bad++; $display("FAIL wrap: got %0h want 0", imem_addr); end
        clear_prog();
        prog[0] = 20'h61033;  // LDI R1,0x33
        prog[1] = 20'h600AA;  // LDI R0,0xAA
        prog[2] = 20'h01000;  // ADD R1,R0,R0
        do_reset();
        step(6);
        n_cmp++; if (dut.u_regfile.regs_q[1] !== 20'h0) begin n_bad++; $display("FAIL r0_read: got %0h want 0", dut.u_regfile.regs_q[1]); end
    endtask

    task automatic test_halt_reset();
        clear_prog();
        prog[0] = 20'h61007;  // LDI R1,7
        prog[1] = I_HALT;
        do_reset();
        step(4);
        n_cmp++; if (retire_cnt !== 32'd2) begin n_bad++; $display("FAIL halt_cnt: got %0d want 2", retire_cnt); end
        for (int i = 0; i < 20; i++) begin
            step(1);
            n_cmp++; if (halted !== 1'b1 || imem_req !== 1'b0 || pc_out !== 12'h001) begin n_bad++; $display("FAIL halt_hold%0d: got h=%0h req=%0h pc=%0h want h=1 req=0 pc=1", i, halted, imem_req, pc_out); end
        end
        clear_prog();
        prog[0] = 20'h61003;  // LDI R1,3
        prog[1] = 20'h62055;  // LDI R2,0x55
        prog[2] = 20'h82100;  // ST R2,[R1]
        prog[3] = 20'h75100;  // LD R5,[R1]
        do_reset();
        step(8);
        n_cmp++; if (pc_out !== 12'h003) begin n_bad++; $display("FAIL midld_pc: got %0h want 3", pc_out); end
        rst = 1'b1;
        #1;
        n_cmp++; if (pc_out !== 12'h000) begin n_bad++; $display("FAIL midld_rst_pc: got %0h want 0", pc_out); end
        n_cmp++; if (retire_cnt !== 32'd0) begin n_bad++; $display("FAIL midld_rst_cnt: got %0d want 0", retire_cnt); end
        n_cmp++; if (dut.u_regfile.regs_q[1] !== 20'h0 || dut.u_regfile.regs_q[2] !== 20'h0) begin n_bad++; $display("FAIL midld_rst_rf: got r1=%0h r2=%0h want 0", dut.u_regfile.regs_q[1], dut.u_regfile.regs_q[2]); end
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL midld_rst_req: got %0h want 0", imem_req); end
        step(2);
        n_cmp++; if (dut.u_regfile.regs_q[5] !== 20'h0) begin n_bad++; $display("FAIL midld_r5: got %0h want 0", dut.u_regfile.regs_q[5]); end
        release_rst();
        step(2);
        n_cmp++; if (retire_cnt !== 32'd1 || imem_addr !== 12'h001) begin n_bad++; $display("FAIL restart: got cnt=%0d addr=%0h want cnt=1 addr=1", retire_cnt, imem_addr); end
        step(7);
        n_cmp++; if (dut.u_regfile.regs_q[5] !== 20'h55) begin n_bad++; $display("FAIL restart_ld: got %0h want 55", dut.u_regfile.regs_q[5]); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_memory();
        test_branch();
        test_wait_states();
        test_wrap_r0();
        test_halt_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
